// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word, opcode field and the HALT opcode.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    localparam opcode_t HALT = 6'b111111;
endpackage

// File: rtl/fetch_pkg.sv
// Fetch-stage types: state encoding, IF/ID latch contents and the bubble value.
package fetch_pkg;
    import cpu_types_pkg::*;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t npc;
        logic  valid;
    } ifid_t;

    // An all-zero instruction decodes as a nop, so a bubble is simply zero.
    localparam ifid_t BUBBLE = '0;

    function automatic logic is_halt(input word_t instr);
        return instr[31:26] == HALT;
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bus between the fetch stage (master) and the icache (slave).
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;

    modport master (input ihit, input imemload, output imemREN, output imemaddr);
    modport slave  (output ihit, output imemload, input imemREN, input imemaddr);
endinterface

// File: rtl/ifid_latch.sv
// IF/ID pipeline register: squash wins over load, otherwise the contents are held.
module ifid_latch
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  srst,
    input  logic  load,
    input  logic  squash,
    input  ifid_t d,
    output ifid_t q
);
    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (squash) begin
            ifid_d = BUBBLE;
        end else if (load) begin
            ifid_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ifid_q <= BUBBLE;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q = ifid_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, FETCH/HOLD state machine and the IF/ID latch.
// Optional performance counters are compiled in with `define FETCH_PERF_CNT_EN.
module fetch_stage
    import cpu_types_pkg::*;
    import fetch_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master imem,
    input  logic          stall,
    input  logic          flush,
    input  logic          redirect_en,
    input  word_t         redirect_pc,
    output word_t         ifid_instr,
    output word_t         ifid_pc,
    output word_t         ifid_npc,
    output logic          ifid_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output word_t         fetch_count,
    output word_t         stall_count
`endif
);
    word_t        pc_q, pc_d;
    fetch_state_t state_q, state_d;
    logic         ifid_load;
    logic         ifid_squash;
    ifid_t        ifid_in;
    ifid_t        ifid_out;
    word_t        pc_plus4;

    // Redirect targets are forced to word alignment; the low bits are dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pc_plus4 = pc_q + 32'd4;
    assign ifid_in  = '{instr: imem.imemload, pc: pc_q, npc: pc_plus4, valid: 1'b1};

    // Priority: redirect > flush > stall > ihit.
    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        ifid_load   = 1'b0;
        ifid_squash = 1'b0;
        if (redirect_en) begin
            pc_d        = {redirect_pc[31:2], 2'b00};
            state_d     = FETCH;
            ifid_squash = 1'b1;
        end else if (flush) begin
            ifid_squash = 1'b1;
        end else if (!stall) begin
            if (state_q == FETCH && imem.ihit) begin
                ifid_load = 1'b1;
                pc_d      = pc_plus4;
                if (is_halt(imem.imemload)) begin
                    state_d = HOLD;
                end
            end else begin
                ifid_squash = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q    <= PC_INIT;
            state_q <= FETCH;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    ifid_latch u_ifid_latch (
        .clk    (CLK),
        .srst   (RST),
        .load   (ifid_load),
        .squash (ifid_squash),
        .d      (ifid_in),
        .q      (ifid_out)
    );

    assign imem.imemaddr = pc_q;
    assign imem.imemREN  = (state_q == FETCH) && !RST;

    assign ifid_instr = ifid_out.instr;
    assign ifid_pc    = ifid_out.pc;
    assign ifid_npc   = ifid_out.npc;
    assign ifid_valid = ifid_out.valid;

`ifdef FETCH_PERF_CNT_EN
    word_t fetch_count_q, fetch_count_d;
    word_t stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + {31'd0, ifid_load};
        stall_count_d = stall_count_q + {31'd0, stall};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline latch.
- Owns the PC and drives the icache request (imemREN/imemaddr). Captures imemload on ihit.
- Presents the latched instruction, PC and PC+4 to decode, where instr feeds the control unit.
- Handles stall from hazard logic, squash, branch/jump redirect, and stops fetching after a HALT.

Parameters:
PC_INIT, 32'h0000_0000, reset fetch address (word aligned)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
ihit  input  1  icache hit; imemload valid this cycle
imemload  input  32  instruction word from icache
imemREN  output  1  instruction read enable
imemaddr  output  32  fetch address (= PC)
stall  input  1  hold PC and IF/ID latch (hazard unit)
flush  input  1  squash IF/ID contents to bubble, PC unchanged
redirect_en  input  1  branch/jump taken; load new PC and squash
redirect_pc  input  32  redirect target
ifid_instr  output  32  latched instruction (32'h0 = nop bubble)
ifid_pc  output  32  PC of latched instruction
ifid_npc  output  32  PC+4 of latched instruction
ifid_valid  output  1  latch holds a real instruction

Behaviour:
- Clock and reset: single clock CLK; RST synchronous, active-high.
- Reset values: PC=PC_INIT, state FETCH, ifid_instr=0, ifid_pc=0, ifid_npc=0, ifid_valid=0.
- imemREN is 0 while RST is high.
- Combinational outputs: imemaddr = PC; imemREN = (state==FETCH) && !RST.
- States:
  - FETCH: normal fetching.
  - HOLD: a HALT has been fetched; no requests are issued.
- Per-cycle update priority, highest first: RST > redirect_en > flush > stall > ihit.
  - redirect_en=1: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (instr 0, valid 0, pc/npc 0); state <= FETCH. Any simultaneous ihit is discarded. Redirect overrides stall.
  - flush=1 (no redirect): IF/ID <= bubble; PC held; ihit discarded; state unchanged.
  - stall=1: PC, IF/ID and state all held; ihit ignored. The cache re-supplies on a later cycle because the address is unchanged. imemREN stays asserted in FETCH.
  - FETCH, ihit=1, no stall: IF/ID <= {imemload, PC, PC+4, valid=1}; PC <= PC+4. If imemload[31:26]==HALT opcode (6'b111111), state <= HOLD.
  - FETCH, ihit=0, no stall: IF/ID <= bubble; PC held.
  - HOLD, no stall: IF/ID <= bubble each cycle; PC held.
- HOLD exits only via redirect_en (the HALT was speculative behind a taken branch) or RST.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.
- Latency: one cycle from ihit to ifid_* valid; one cycle from redirect_en to imemaddr showing the target.
- Reset mid-miss: the outstanding request is abandoned; the next cycle fetches PC_INIT.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on each accepted ihit (IF/ID loaded with valid=1).
  - stall_count increments on each cycle with stall=1 and RST=0.
  - Both wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- cpu_types_pkg supplies word_t, opcode_t and the HALT opcode constant.
- New fetch_pkg holds fetch_state_t enum {FETCH, HOLD}, ifid_t packed struct {instr, pc, npc, valid}, and the BUBBLE constant for ifid_t.
- One natural sub-module, ifid_latch: registered ifid_t with load/hold/squash controls. The PC and state machine stay in fetch_stage.

Test Plan:
- Reset, then ihit=1 every cycle, imemload = 0x2001000A, 0x20020003, … → imemaddr sequence 0, 4, 8; ifid_pc lags by one cycle; ifid_npc = ifid_pc+4; ifid_valid=1.
- ihit low for 3 cycles at PC=0x10 → imemaddr stays 0x10; ifid_valid=0 and ifid_instr=0 for 3 cycles; on the next ihit, ifid_pc=0x10.
- stall=1 for 2 cycles with ihit=1 → PC and ifid_* frozen; after release, fetch resumes at the same PC with no instruction lost or duplicated.
- redirect_en=1, redirect_pc=0x0000_0103, with stall=1 and ihit=1 in the same cycle → next imemaddr=0x100; ifid_valid=0.
- imemload=0xFFFFFFFF on ihit → state HOLD; imemREN=0 from the next cycle. Subsequent redirect_en to 0x40 → imemREN=1, imemaddr=0x40.
- PC=0xFFFF_FFFC with ihit → next imemaddr=0x0; ifid_npc=0x0. With FETCH_PERF_CNT_EN defined, fetch_count increments by exactly the number of accepted hits.
